// File: rtl/vga_sync_gen.sv
// VGA timing generator: raw active-region syncs and counters for the game, plus a
// delay-aligned, porched and blanked pin stage. Optional colour bars via VGA_TEST_PATTERN_EN.
module vga_sync_gen #(
    parameter int c_TOTAL_COLS  = 800,
    parameter int c_TOTAL_ROWS  = 525,
    parameter int c_ACTIVE_COLS = 640,
    parameter int c_ACTIVE_ROWS = 480,
    parameter int c_H_FRONT     = 18,
    parameter int c_H_SYNC      = 96,
    parameter int c_V_FRONT     = 10,
    parameter int c_V_SYNC      = 2,
    parameter int c_VIDEO_DELAY = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       i_Pattern_Sel,
`endif
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic       o_VGA_HSync,
    output logic       o_VGA_VSync,
    output logic [3:0] o_VGA_Red,
    output logic [3:0] o_VGA_Grn,
    output logic [3:0] o_VGA_Blu
);

    localparam logic [9:0] LAST_COL   = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW   = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS   = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS   = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] H_LOW_BEG  = 10'(c_ACTIVE_COLS + c_H_FRONT);
    localparam logic [9:0] H_LOW_END  = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
    localparam logic [9:0] V_LOW_BEG  = 10'(c_ACTIVE_ROWS + c_V_FRONT);
    localparam logic [9:0] V_LOW_END  = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

    // run stays low for the first cycle after release so counters start at col 0, row 0
    logic       run;
    logic [9:0] col;
    logic [9:0] row;
    logic [7:0] frame;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            run   <= 1'b0;
            col   <= '0;
            row   <= '0;
            frame <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        frame <= frame + 8'd1;
                    end else begin
                        row <= row + 10'd1;
                    end
                end else begin
                    col <= col + 10'd1;
                end
            end
        end
    end

    logic active;
    logic h_low;
    logic v_low;

    always_comb begin
        o_HSync       = run && (col < ACT_COLS);
        o_VSync       = run && (row < ACT_ROWS);
        o_Frame_Start = run && (col == 10'd0) && (row == 10'd0);
        active        = o_HSync && o_VSync;
        h_low         = run && (col >= H_LOW_BEG) && (col < H_LOW_END);
        v_low         = run && (row >= V_LOW_BEG) && (row < V_LOW_END);
    end

    assign o_Col_Count   = col;
    assign o_Row_Count   = row;
    assign o_Frame_Count = frame;

    logic dly_act [c_VIDEO_DELAY];
    logic dly_hl  [c_VIDEO_DELAY];
    logic dly_vl  [c_VIDEO_DELAY];
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0] dly_col [c_VIDEO_DELAY];
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < c_VIDEO_DELAY; i++) begin
                dly_act[i] <= 1'b0;
                dly_hl[i]  <= 1'b0;
                dly_vl[i]  <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
                dly_col[i] <= '0;
`endif
            end
        end else begin
            dly_act[0] <= active;
            dly_hl[0]  <= h_low;
            dly_vl[0]  <= v_low;
`ifdef VGA_TEST_PATTERN_EN
            dly_col[0] <= col[9:6];
`endif
            for (int i = 1; i < c_VIDEO_DELAY; i++) begin
                dly_act[i] <= dly_act[i-1];
                dly_hl[i]  <= dly_hl[i-1];
                dly_vl[i]  <= dly_vl[i-1];
`ifdef VGA_TEST_PATTERN_EN
                dly_col[i] <= dly_col[i-1];
`endif
            end
        end
    end

    logic [11:0] pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] bar_rgb;
    logic [3:0]  bar_col;

    // col[9] set means 512..639 in the active region: white bar
    always_comb begin
        bar_col = dly_col[c_VIDEO_DELAY-1];
        if (bar_col[3])
            bar_rgb = 12'hFFF;
        else
            bar_rgb = {{4{bar_col[2]}}, {4{bar_col[1]}}, {4{bar_col[0]}}};
        pix_rgb = i_Pattern_Sel ? bar_rgb : {i_Red_Video, i_Grn_Video, i_Blu_Video};
    end
`else
    assign pix_rgb = {i_Red_Video, i_Grn_Video, i_Blu_Video};
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_VGA_HSync <= 1'b1;
            o_VGA_VSync <= 1'b1;
            o_VGA_Red   <= '0;
            o_VGA_Grn   <= '0;
            o_VGA_Blu   <= '0;
        end else begin
            o_VGA_HSync <= ~dly_hl[c_VIDEO_DELAY-1];
            o_VGA_VSync <= ~dly_vl[c_VIDEO_DELAY-1];
            if (dly_act[c_VIDEO_DELAY-1]) begin
                o_VGA_Red <= pix_rgb[11:8];
                o_VGA_Grn <= pix_rgb[7:4];
                o_VGA_Blu <= pix_rgb[3:0];
            end else begin
                o_VGA_Red <= '0;
                o_VGA_Grn <= '0;
                o_VGA_Blu <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing and a tiny-timing instance checked every cycle
// against an arithmetic model derived from cycles since reset release, plus literal pins.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] red_in, grn_in, blu_in;
    logic       pat_sel;

    logic       hs [2], vs [2], fs [2], vga_hs [2], vga_vs [2];
    logic [9:0] col [2], row [2];
    logic [7:0] frame [2];
    logic [3:0] vr [2], vg [2], vb [2];

    always #5 clk = ~clk;

    vga_sync_gen u_dflt (
        .i_Clk(clk), .i_Rst(rst),
        .o_HSync(hs[0]), .o_VSync(vs[0]),
        .o_Col_Count(col[0]), .o_Row_Count(row[0]),
        .o_Frame_Start(fs[0]), .o_Frame_Count(frame[0]),
`ifdef VGA_TEST_PATTERN_EN
        .i_Pattern_Sel(pat_sel),
`endif
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_VGA_HSync(vga_hs[0]), .o_VGA_VSync(vga_vs[0]),
        .o_VGA_Red(vr[0]), .o_VGA_Grn(vg[0]), .o_VGA_Blu(vb[0])
    );

    vga_sync_gen #(
        .c_TOTAL_COLS(16), .c_TOTAL_ROWS(8), .c_ACTIVE_COLS(8), .c_ACTIVE_ROWS(4),
        .c_H_FRONT(2), .c_H_SYNC(2), .c_V_FRONT(1), .c_V_SYNC(1), .c_VIDEO_DELAY(1)
    ) u_small (
        .i_Clk(clk), .i_Rst(rst),
        .o_HSync(hs[1]), .o_VSync(vs[1]),
        .o_Col_Count(col[1]), .o_Row_Count(row[1]),
        .o_Frame_Start(fs[1]), .o_Frame_Count(frame[1]),
`ifdef VGA_TEST_PATTERN_EN
        .i_Pattern_Sel(pat_sel),
`endif
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_VGA_HSync(vga_hs[1]), .o_VGA_VSync(vga_vs[1]),
        .o_VGA_Red(vr[1]), .o_VGA_Grn(vg[1]), .o_VGA_Blu(vb[1])
    );

    int TC [2] = '{800, 16};
    int TR [2] = '{525, 8};
    int AC [2] = '{640, 8};
    int AR [2] = '{480, 4};
    int HF [2] = '{18, 2};
    int HW [2] = '{96, 2};
    int VF [2] = '{10, 1};
    int VW [2] = '{2, 1};
    int DL [2] = '{2, 1};

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bars(input int c);
        int k;
        if (c >= 512) return 12'hFFF;
        k = c / 64;
        return (((k / 4) % 2) ? 12'hF00 : 0) | (((k / 2) % 2) ? 12'h0F0 : 0) | ((k % 2) ? 12'h00F : 0);
    endfunction

    localparam int RST_AT = 41 * 800 + 300;  // default instance at col 300
    localparam int CYCLES = 35200;

    bit run = 0;
    int n   = 0;
    bit rst_applied;
    int hold;
    bit did_mid_reset = 0;
    logic [11:0] samp_rgb;
    logic        samp_sel;

    initial begin
        rst = 1'b1; red_in = '0; grn_in = '0; blu_in = '0; pat_sel = 1'b0;
        hold = 5;
        for (int i = 0; i < CYCLES; i++) begin
            @(posedge clk);
            rst_applied = rst;
            samp_rgb    = {red_in, grn_in, blu_in};
            samp_sel    = pat_sel;
            if (rst_applied) begin
                run = 0; n = 0;
            end else if (!run) begin
                run = 1; n = 0;
            end else begin
                n++;
            end

            #1;
            if (run && n == RST_AT && !did_mid_reset) begin
                rst = 1'b1; hold = 5; did_mid_reset = 1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                red_in = 4'hF; grn_in = 4'hF; blu_in = 4'hF;
            end else begin
                red_in = 4'($urandom); grn_in = 4'($urandom); blu_in = 4'($urandom);
            end
            pat_sel = 1'($urandom);

            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int ec, er, ef, m, mc, mr, ergb;
                bit ehs, evs, efs, act, hl, vl;
                string s;
                s = (k == 0) ? "dflt" : "small";
                ec = 0; er = 0; ef = 0; ehs = 0; evs = 0; efs = 0;
                act = 0; hl = 0; vl = 0; ergb = 0;
                if (run) begin
                    ec  = n % TC[k];
                    er  = (n / TC[k]) % TR[k];
                    ef  = (n / (TC[k] * TR[k])) % 256;
                    ehs = ec < AC[k];
                    evs = er < AR[k];
                    efs = (ec == 0) && (er == 0);
                    m = n - DL[k] - 1;
                    if (m >= 0) begin
                        mc  = m % TC[k];
                        mr  = (m / TC[k]) % TR[k];
                        act = (mc < AC[k]) && (mr < AR[k]);
                        hl  = (mc >= AC[k] + HF[k]) && (mc < AC[k] + HF[k] + HW[k]);
                        vl  = (mr >= AR[k] + VF[k]) && (mr < AR[k] + VF[k] + VW[k]);
                        ergb = int'(samp_rgb);
`ifdef VGA_TEST_PATTERN_EN
                        if (samp_sel) ergb = bars(mc);
`endif
                        if (!act) ergb = 0;
                    end
                end
                chk({s, ".col"}, int'(col[k]), ec);
                chk({s, ".row"}, int'(row[k]), er);
                chk({s, ".frame"}, int'(frame[k]), ef);
                chk({s, ".hsync"}, int'(hs[k]), int'(ehs));
                chk({s, ".vsync"}, int'(vs[k]), int'(evs));
                chk({s, ".fstart"}, int'(fs[k]), int'(efs));
                chk({s, ".vga_hs"}, int'(vga_hs[k]), int'(!hl));
                chk({s, ".vga_vs"}, int'(vga_vs[k]), int'(!vl));
                chk({s, ".vga_rgb"}, int'({vr[k], vg[k], vb[k]}), ergb);
            end

            if (rst_applied) begin
                chk("pin.rst_col", int'(col[0]), 0);
                chk("pin.rst_hsync", int'(hs[0]), 0);
                chk("pin.rst_vga_hs", int'(vga_hs[0]), 1);
                chk("pin.rst_vga_vs", int'(vga_vs[0]), 1);
                chk("pin.rst_red", int'(vr[0]), 0);
            end
            if (run) begin
                if (n == 0) begin
                    chk("pin.start_col", int'(col[0]), 0);
                    chk("pin.start_row", int'(row[0]), 0);
                    chk("pin.start_hs", int'(hs[0]), 1);
                    chk("pin.start_vs", int'(vs[0]), 1);
                    chk("pin.start_fs", int'(fs[0]), 1);
                end
                if (n == 639) chk("pin.col639_hs", int'(hs[0]), 1);
                if (n == 640) chk("pin.col640_hs", int'(hs[0]), 0);
                if (n == 660) chk("pin.vga_hs_660", int'(vga_hs[0]), 1);
                if (n == 661) chk("pin.vga_hs_661", int'(vga_hs[0]), 0);
                if (n == 756) chk("pin.vga_hs_756", int'(vga_hs[0]), 0);
                if (n == 757) chk("pin.vga_hs_757", int'(vga_hs[0]), 1);
                if (n == 12)  chk("pin.small_vga_hs_12", int'(vga_hs[1]), 0);
                if (n == 81)  chk("pin.small_vga_vs_81", int'(vga_vs[1]), 1);
                if (n == 82)  chk("pin.small_vga_vs_82", int'(vga_vs[1]), 0);
                if (n == 97)  chk("pin.small_vga_vs_97", int'(vga_vs[1]), 0);
                if (n == 98)  chk("pin.small_vga_vs_98", int'(vga_vs[1]), 1);
                if (n == 32767) chk("pin.small_frame_255", int'(frame[1]), 255);
                if (n == 32768) begin
                    chk("pin.small_frame_wrap", int'(frame[1]), 0);
                    chk("pin.small_fs_wrap", int'(fs[1]), 1);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
